// File: rtl/mem_map_pkg.sv
// Purpose : shared memory-map constants and FSM state encoding for the memory access master.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: default region bases, the beat stride between burst words, and the master's state enum.
package mem_map_pkg;

  localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;

  // Byte distance between consecutive burst beats (one word).
  localparam int BEAT_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/addr_decoder.sv
// Purpose : decides whether a beat address hits ROM or RAM and whether the access is legal.
// Latency : purely combinational.
// Backpressure : none.
// Ports   : i_addr (byte address), i_we (write flag) -> o_legal (aligned, in a region, no ROM write).
module addr_decoder
  import mem_map_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE     = DATA_WIDTH'(ROM_BASE_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = DATA_WIDTH'(RAM_BASE_DEFAULT)
) (
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  output logic                  o_legal
);

  // One extra bit so a region ending at the top of the address space does not wrap its limit.
  localparam int AW = DATA_WIDTH + 1;
  localparam logic [AW-1:0] REGION_BYTES = AW'(BEAT_STRIDE * MEMORY_DEPTH);
  localparam logic [AW-1:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [AW-1:0] ROM_HI = ROM_LO + REGION_BYTES;
  localparam logic [AW-1:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [AW-1:0] RAM_HI = RAM_LO + REGION_BYTES;

  logic [AW-1:0] w_addr_x;
  logic          w_rom_hit;
  logic          w_ram_hit;
  logic          w_aligned;

  assign w_addr_x  = {1'b0, i_addr};
  assign w_rom_hit = (w_addr_x >= ROM_LO) && (w_addr_x < ROM_HI);
  assign w_ram_hit = (w_addr_x >= RAM_LO) && (w_addr_x < RAM_HI);
  assign w_aligned = (i_addr[1:0] == 2'b00);

  // ROM is read-only: a write there is illegal even though the address hits.
  assign o_legal = w_aligned && (w_ram_hit || (w_rom_hit && !i_we));

endmodule

// File: rtl/memory_access_master.sv
// Purpose : turns single writes and short read bursts into one-word memory accesses with a response per beat.
// Latency : request accepted at edge N, response valid from cycle N+2; beats spaced 2 cycles when rsp_ready held.
// Backpressure : req_ready only in IDLE; a response is held stable until rsp_ready.
// Ports   : clk/reset; req_* request channel; Address_o/Write_Data_o/Write_Enable_o/Read_Data_i memory side;
//           rsp_* response channel (rdata forced to 0 and err set for illegal beats).
module memory_access_master
  import mem_map_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE     = DATA_WIDTH'(ROM_BASE_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = DATA_WIDTH'(RAM_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_len,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Write_Enable_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_beats;  // beats still to issue, including the one in flight
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_access;
  logic w_legal;

  addr_decoder #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ROM_BASE     (ROM_BASE),
    .RAM_BASE     (RAM_BASE)
  ) u_addr_decoder (
    .i_addr  (r_addr),
    .i_we    (r_we),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_beats <= 3'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_beats <= req_we ? 3'd1 : ({1'b0, req_len} + 3'd1);
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rdata <= (w_legal && !r_we) ? Read_Data_i : '0;
          r_err   <= !w_legal;
          r_beats <= r_beats - 3'd1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            // An error ends the burst even if beats remain.
            if ((r_beats != 3'd0) && !r_err) begin
              r_addr  <= r_addr + DATA_WIDTH'(BEAT_STRIDE);
              r_state <= ST_ACCESS;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == ST_ACCESS);

  assign Address_o    = w_access ? r_addr  : '0;
  assign Write_Data_o = w_access ? r_wdata : '0;
  // Gated by reset so a reset landing on the access cycle never commits the write.
  assign Write_Enable_o = w_access && r_we && w_legal && !reset;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_memory_access_master.sv
module tb_memory_access_master;

  localparam int          DEPTH = 32;
  localparam int          DW    = 32;
  localparam logic [31:0] ROM   = 32'h0040_0000;
  localparam logic [31:0] RAM   = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_len;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] Address_o;
  logic [DW-1:0] Write_Data_o;
  logic          Write_Enable_o;
  logic [DW-1:0] Read_Data_i;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  memory_access_master #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (DW),
    .ROM_BASE     (ROM),
    .RAM_BASE     (RAM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_len        (req_len),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .Address_o      (Address_o),
    .Write_Data_o   (Write_Data_o),
    .Write_Enable_o (Write_Enable_o),
    .Read_Data_i    (Read_Data_i),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory system driven by the DUT, plus an independent shadow used for predictions.
  logic [31:0] rom_m   [DEPTH];
  logic [31:0] ram_m   [DEPTH];
  logic [31:0] ram_exp [DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int errors   = 0;
  int checks   = 0;
  int we_count = 0;

  function automatic logic in_rom(input logic [31:0] a);
    return (a >= ROM) && (a < ROM + 32'(4 * DEPTH));
  endfunction

  function automatic logic in_ram(input logic [31:0] a);
    return (a >= RAM) && (a < RAM + 32'(4 * DEPTH));
  endfunction

  always_comb begin
    Read_Data_i = 32'hDEAD_BEEF;
    if (in_rom(Address_o)) Read_Data_i = rom_m[(Address_o - ROM) >> 2];
    else if (in_ram(Address_o)) Read_Data_i = ram_m[(Address_o - RAM) >> 2];
  end

  always @(posedge clk) begin
    if (Write_Enable_o === 1'b1 && in_ram(Address_o)) ram_m[(Address_o - RAM) >> 2] <= Write_Data_o;
  end

  always @(negedge clk) begin
    if (Write_Enable_o === 1'b1) we_count++;
  end

  // Reference model: expected response stream for one request.
  task automatic predict(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic [31:0] a;
    logic        legal;
    exp_t        e;
    a = addr;
    for (int i = 0; i < (we ? 1 : int'(len) + 1); i++) begin
      legal = (a[1:0] == 2'b00) && (in_ram(a) || (!we && in_rom(a)));
      e.err   = !legal;
      e.rdata = 32'h0;
      if (legal && !we) e.rdata = in_rom(a) ? rom_m[(a - ROM) >> 2] : ram_exp[(a - RAM) >> 2];
      if (legal && we) ram_exp[(a - RAM) >> 2] = wdata;
      sb.push_back(e);
      if (!legal) break;
      a = a + 32'd4;
    end
  endtask

  // Leaves the bench #1 after the accepting edge, i.e. inside the ACCESS cycle.
  task automatic issue(input logic we, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic pred);
    int t;
    req_we    = we;
    req_len   = len;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    if (pred) predict(we, len, addr, wdata);
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Pops and compares n responses with rsp_ready held high; each must arrive one edge after the previous point.
  task automatic collect(input int n);
    int   t;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (rsp_valid !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL rsp_timeout beat %0d: rsp_valid=%b required 1", k, rsp_valid);
        return;
      end
      checks++;
      if (t != 1) begin
        errors++;
        $display("FAIL rsp_latency beat %0d: waited %0d cycles required 1", k, t);
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty beat %0d: extra response rdata=%h", k, rsp_rdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata beat %0d: got %h required %h", k, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err beat %0d: got %b required %b", k, rsp_err, e.err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, Write_Enable_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err/we=%b required 1000",
               {req_ready, rsp_valid, rsp_err, Write_Enable_o});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || Address_o !== 32'h0 || Write_Data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", rsp_rdata, Address_o, Write_Data_o);
    end
  endtask

  task automatic test_write_read();
    int w0;
    w0 = we_count;
    issue(1'b1, 2'd0, 32'h1001_0008, 32'h1234_5678, 1'b1);
    checks++;
    if (Write_Enable_o !== 1'b1 || Address_o !== 32'h1001_0008 || Write_Data_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_access: we=%b addr=%h wdata=%h required 1 10010008 12345678",
               Write_Enable_o, Address_o, Write_Data_o);
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL access_flags: rsp_valid=%b req_ready=%b required 0 0", rsp_valid, req_ready);
    end
    collect(1);
    checks++;
    if (we_count - w0 != 1) begin
      errors++;
      $display("FAIL write_strobe_cycles: got %0d required 1", we_count - w0);
    end
    checks++;
    if (Address_o !== 32'h0 || Write_Data_o !== 32'h0) begin
      errors++;
      $display("FAIL idle_mem_outputs: addr=%h wdata=%h required 0", Address_o, Write_Data_o);
    end
    issue(1'b0, 2'd0, 32'h1001_0008, 32'h0, 1'b1);
    collect(1);
  endtask

  task automatic test_rom_burst();
    issue(1'b0, 2'd3, ROM, 32'h0, 1'b1);
    collect(4);
    checks++;
    if (req_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL burst_done: req_ready=%b pending=%0d required 1 0", req_ready, sb.size());
    end
  endtask

  task automatic test_errors();
    int w0;
    w0 = we_count;
    issue(1'b1, 2'd0, 32'h0040_0004, 32'hFFFF_FFFF, 1'b1);
    collect(1);
    checks++;
    if (we_count != w0) begin
      errors++;
      $display("FAIL rom_write_strobe: got %0d cycles required 0", we_count - w0);
    end
    issue(1'b0, 2'd0, 32'h1001_0002, 32'h0, 1'b1);
    collect(1);
  endtask

  task automatic test_region_end();
    int extra;
    issue(1'b0, 2'd3, RAM + 32'(4 * (DEPTH - 2)), 32'h0, 1'b1);
    collect(3);
    extra = 0;
    repeat (6) begin
      if (rsp_valid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst_terminate: extra_valid_cycles=%0d req_ready=%b required 0 1", extra, req_ready);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL burst_pending: %0d expected responses left required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int   t;
    exp_t e;
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, 32'h1001_0008, 32'h0, 1'b1);
    // A request offered during ACCESS/RESP must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_addr = RAM; req_wdata = 32'hBAD0_BAD0;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    e = sb.pop_front();
    repeat (5) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL stall_hold: valid=%b rdata=%h err=%b required 1 %h %b",
                 rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
    // RAM[0] must still hold its original value.
    issue(1'b0, 2'd0, RAM, 32'h0, 1'b1);
    collect(1);
  endtask

  task automatic test_reset_in_access();
    int w0;
    w0 = we_count;
    issue(1'b1, 2'd0, RAM + 32'h10, 32'hCAFE_F00D, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (Write_Enable_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate_we: got %b required 0", Write_Enable_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, Write_Enable_o} !== 4'b1000 || rsp_rdata !== 32'h0 ||
        Address_o !== 32'h0 || Write_Data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_access: ready/valid/err/we=%b rdata=%h addr=%h wdata=%h required 1000 0 0 0",
               {req_ready, rsp_valid, rsp_err, Write_Enable_o}, rsp_rdata, Address_o, Write_Data_o);
    end
    reset = 1'b0;
    checks++;
    if (we_count != w0) begin
      errors++;
      $display("FAIL reset_write_strobe: got %0d cycles required 0", we_count - w0);
    end
    issue(1'b0, 2'd0, RAM + 32'h10, 32'h0, 1'b1);
    collect(1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom_m[i]   = 32'hA500_0000 + 32'(i) * 32'h0011_0003;
      ram_m[i]   = 32'h5A00_0000 + 32'(i);
      ram_exp[i] = 32'h5A00_0000 + 32'(i);
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_len   = 2'd0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    test_reset();
    test_write_read();
    test_rom_burst();
    test_errors();
    test_region_end();
    test_stall();
    test_reset_in_access();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_access_master.md
MEMORY_ACCESS_MASTER -- requirements
Module: memory_access_master

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 32, meaning words per region (ROM and RAM each).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data and address width.
REQ-003 The block SHALL have parameter ROM_BASE, default 32'h00400000, meaning the instruction region byte base.
REQ-004 The block SHALL have parameter RAM_BASE, default 32'h10010000, meaning the data region byte base.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-008 req_we  in  1  1=write, 0=read; req_len  in  2  read burst beats minus one (ignored for writes).
REQ-009 req_addr  in  DATA_WIDTH  byte address; req_wdata  in  DATA_WIDTH  write data.
REQ-010 Address_o  out  DATA_WIDTH  byte address to memory system; Write_Data_o  out  DATA_WIDTH  write data to memory.
REQ-011 Write_Enable_o  out  1  memory write strobe; Read_Data_i  in  DATA_WIDTH  combinational read data from memory.
REQ-012 rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  DATA_WIDTH; rsp_err  out  1  response channel.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-014 IDLE -> ACCESS on req_valid; block SHALL latch addr, we, wdata, beat count (req_len+1 for reads, 1 for writes).
REQ-015 ACCESS SHALL last exactly one cycle: Address_o = current beat address, Write_Data_o = latched wdata, Write_Enable_o = we and beat legal; outside ACCESS all three SHALL be 0.
REQ-016 In ACCESS, rsp_rdata SHALL capture Read_Data_i for legal reads, 0 for writes and illegal beats; rsp_err captures the beat legality result; then -> RESP.
REQ-017 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready; on handshake: if beats remain and no error, address += 4 and -> ACCESS; else -> IDLE.
REQ-018 Latency: request accepted at edge N, rsp_valid SHALL be high from cycle N+2; back-to-back beats spaced 2 cycles with rsp_ready held high.
REQ-019 Beat legal SHALL require addr[1:0]==0 and addr within [ROM_BASE, ROM_BASE+4*MEMORY_DEPTH) or [RAM_BASE, RAM_BASE+4*MEMORY_DEPTH), and no write to ROM region.
REQ-020 Illegal beat SHALL cause no memory write, rsp_err=1, rsp_rdata=0, and terminate the burst after its response.
REQ-021 Burst crossing a region end SHALL error on the first out-of-range beat; earlier beats complete normally.
REQ-022 Address increment SHALL be modulo 2^DATA_WIDTH; wrap to 0 falls out of range and errors.
REQ-023 req_valid during ACCESS/RESP SHALL be ignored (not accepted, not latched).

Reset
REQ-024 reset SHALL force IDLE at the edge; rsp_valid, rsp_err, rsp_rdata, latched registers, beat counter SHALL be 0; req_ready=1 the cycle after.
REQ-025 Write_Enable_o SHALL be gated by !reset so reset asserted during ACCESS produces no write; pending burst beats SHALL be discarded.

Structure
REQ-026 Package mem_map_pkg SHALL hold ROM_BASE/RAM_BASE defaults, the state enum, and the beat-stride constant 4.
REQ-027 One combinational sub-module addr_decoder SHALL compute region hit and legality from address, we, MEMORY_DEPTH.

Verification
REQ-028 Write 32'h12345678 to 32'h10010008, then read it -> Write_Enable_o high exactly one cycle; read rsp_rdata=32'h12345678, rsp_err=0, rsp_valid at N+2.
REQ-029 Read burst req_len=3 at 32'h00400000 -> four responses at 0x400000/4/8/C with ROM contents, rsp_err=0 each.
REQ-030 Write to 32'h00400004 -> no Write_Enable_o, rsp_err=1, rsp_rdata=0; read of 32'h10010002 -> rsp_err=1.
REQ-031 Read burst req_len=3 at RAM_BASE+4*(MEMORY_DEPTH-2) -> two good beats, third rsp_err=1, FSM returns to IDLE, no fourth beat.
REQ-032 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable; reset asserted in ACCESS of a write -> no write, all outputs 0, req_ready=1 next cycle.
